// File: rtl/sram_stream_adapter.sv
// sram_stream_adapter: valid/ready front-end for a single-port SRAM with fixed read latency.
// Requests (read or write) are forwarded to the SRAM when a response credit is available.
// Read data is tracked through the SRAM latency and parked in a response FIFO so the
// consumer can backpressure without data loss.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i / req_ready_o       request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_be_i           request fields (write enable, word address, data, byte enables)
//   rsp_valid_o / rsp_ready_i       read response handshake
//   rsp_rdata_o                     read data (head of the response FIFO)
//   sram_req_o, sram_we_o,
//   sram_addr_o, sram_wdata_o,
//   sram_be_o                       SRAM request port
//   sram_rdata_i                    SRAM read data
module sram_stream_adapter #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 2,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    if (Latency < 1) begin : g_bad_latency
        $error("sram_stream_adapter: Latency must be >= 1");
    end
    if (RspDepth < 1) begin : g_bad_depth
        $error("sram_stream_adapter: RspDepth must be >= 1");
    end

    logic [CntWidth-1:0]  outstanding_q, outstanding_d;
    logic [Latency-1:0]   track_q, track_d;
    logic [Latency:0]     track_ext;
    logic [PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [DataWidth-1:0] mem_q [RspDepth];
    logic                 rd_hs, rsp_hs, push;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every accepted read reserves a FIFO slot until its response is popped, so the
    // FIFO can never overflow and ready never depends on rsp_ready_i combinationally.
    assign req_ready_o  = outstanding_q < CntWidth'(RspDepth);
    assign sram_req_o   = req_valid_i & req_ready_o;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;
    assign rd_hs        = sram_req_o & ~req_we_i;
    assign rsp_valid_o  = cnt_q != '0;
    assign rsp_hs       = rsp_valid_o & rsp_ready_i;
    assign push         = track_q[Latency-1];
    assign rsp_rdata_o  = mem_q[rptr_q];

    always_comb begin
        outstanding_d = outstanding_q + CntWidth'(rd_hs) - CntWidth'(rsp_hs);
        track_ext     = {track_q, rd_hs};
        track_d       = track_ext[Latency-1:0];
        wptr_d        = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d        = rsp_hs ? ptr_inc(rptr_q) : rptr_q;
        cnt_d         = cnt_q + CntWidth'(push) - CntWidth'(rsp_hs);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            track_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            track_q       <= track_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            cnt_q         <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= sram_rdata_i;
    end

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && cnt_q == CntWidth'(RspDepth) && !rsp_hs));
    a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_hs && outstanding_q == '0));
    a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= CntWidth'(RspDepth));

endmodule
